// File: rtl/hash_sched_pkg.sv
// ============================================================================
// Module : hash_sched_pkg
// Shared state encoding, slot indices and helpers for the hash slot scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hash_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic SLOT0 = 1'b0;
    localparam logic SLOT1 = 1'b1;

    function automatic logic [1:0] slot_onehot(input logic slot);
        return (slot == SLOT1) ? 2'b10 : 2'b01;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hash_slot_sched_rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Two-request round-robin arbiter; ptr_i names the slot that wins a tie.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arb2
    import hash_sched_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic       gnt_vld_o,
    output logic       gnt_idx_o
);

    always_comb begin
        gnt_vld_o = |req_i;
        gnt_idx_o = SLOT0;
        case (req_i)
            2'b11:   gnt_idx_o = ptr_i;
            2'b10:   gnt_idx_o = SLOT1;
            default: gnt_idx_o = SLOT0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/hash_slot_sched.sv
// ============================================================================
// Module : hash_slot_sched
// Shares one hash core between two parameter slots: queue, arbitrate, launch,
// watchdog and retire each job.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hash_slot_sched
    import hash_sched_pkg::*;
#(
    parameter int TO_CYC = 4096
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr_hash,
    input  logic s0_req,
    input  logic s0_prm_vld,
    input  logic s0_flg_384,
    output logic s0_ack,
    output logic s0_done,
    output logic s0_err,
    output logic s0_prm_clr,
    input  logic s1_req,
    input  logic s1_prm_vld,
    input  logic s1_flg_384,
    output logic s1_ack,
    output logic s1_done,
    output logic s1_err,
    output logic s1_prm_clr,
    output logic core_start,
    output logic core_slot,
    output logic core_mode,
    input  logic core_done,
    output logic busy
);

    localparam int          TO_W     = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    state_e            state_q, state_d;
    logic [1:0]        pend_q,  pend_d;
    logic              rr_q,    rr_d;
    logic              slot_q,  slot_d;
    logic              mode_q,  mode_d;
    logic              err_q,   err_d;
    logic [TO_W-1:0]   timer_q, timer_d;

    logic [1:0]        w_req;
    logic [1:0]        w_vld;
    logic [1:0]        w_elig;
    logic [1:0]        w_gnt_oh;
    logic              w_gnt_vld;
    logic              w_gnt_idx;

    assign w_req  = {s1_req, s0_req};
    assign w_vld  = {s1_prm_vld, s0_prm_vld};
    // A request arriving this cycle is eligible immediately, giving one-cycle launch latency.
    assign w_elig = (pend_q | w_req) & w_vld;

    rr_arb2 u_arb (
        .req_i     (w_elig),
        .ptr_i     (rr_q),
        .gnt_vld_o (w_gnt_vld),
        .gnt_idx_o (w_gnt_idx)
    );

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        slot_d   = slot_q;
        mode_d   = mode_q;
        err_d    = err_q;
        timer_d  = timer_q;
        w_gnt_oh = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (w_gnt_vld) begin
                    slot_d   = w_gnt_idx;
                    mode_d   = (w_gnt_idx == SLOT1) ? s1_flg_384 : s0_flg_384;
                    w_gnt_oh = slot_onehot(w_gnt_idx);
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (timer_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_q + TO_W'(1);
                end
            end
            ST_DONE: begin
                rr_d    = ~slot_q;
                timer_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A fresh request only survives its own grant if it re-asks for an already-pending slot.
        pend_d = (pend_q | w_req) & ~(w_gnt_oh & ~(pend_q & w_req));

        if (clr_hash) begin
            state_d = ST_IDLE;
            pend_d  = 2'b00;
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= 2'b00;
            rr_q    <= SLOT0;
            slot_q  <= SLOT0;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            rr_q    <= rr_d;
            slot_q  <= slot_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    logic w_in_start;
    logic w_in_done;

    assign w_in_start = (state_q == ST_START);
    assign w_in_done  = (state_q == ST_DONE);

    assign busy       = (state_q != ST_IDLE);
    assign core_start = w_in_start;
    assign core_slot  = busy & slot_q;
    assign core_mode  = busy & mode_q;

    assign s0_ack     = w_in_start & (slot_q == SLOT0);
    assign s1_ack     = w_in_start & (slot_q == SLOT1);
    assign s0_done    = w_in_done  & (slot_q == SLOT0);
    assign s1_done    = w_in_done  & (slot_q == SLOT1);
    assign s0_err     = s0_done & err_q;
    assign s1_err     = s1_done & err_q;
    assign s0_prm_clr = s0_done;
    assign s1_prm_clr = s1_done;

endmodule

`default_nettype wire

// File: tb/tb_hash_slot_sched.sv
// ============================================================================
// Module : tb_hash_slot_sched
// Directed bench with an expectation queue drained by an output monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hash_slot_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_hash = 1'b0;
    logic s0_req = 1'b0, s0_prm_vld = 1'b0, s0_flg_384 = 1'b0;
    logic s1_req = 1'b0, s1_prm_vld = 1'b0, s1_flg_384 = 1'b0;
    logic core_done = 1'b0;
    logic s0_ack, s0_done, s0_err, s0_prm_clr;
    logic s1_ack, s1_done, s1_err, s1_prm_clr;
    logic core_start, core_slot, core_mode, busy;

    hash_slot_sched #(.TO_CYC(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_hash   (clr_hash),
        .s0_req     (s0_req),
        .s0_prm_vld (s0_prm_vld),
        .s0_flg_384 (s0_flg_384),
        .s0_ack     (s0_ack),
        .s0_done    (s0_done),
        .s0_err     (s0_err),
        .s0_prm_clr (s0_prm_clr),
        .s1_req     (s1_req),
        .s1_prm_vld (s1_prm_vld),
        .s1_flg_384 (s1_flg_384),
        .s1_ack     (s1_ack),
        .s1_done    (s1_done),
        .s1_err     (s1_err),
        .s1_prm_clr (s1_prm_clr),
        .core_start (core_start),
        .core_slot  (core_slot),
        .core_mode  (core_mode),
        .core_done  (core_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind 0 = launch (flag = mode), kind 1 = retire (flag = err)
    typedef struct {
        int kind;
        int slot;
        int flag;
        int c;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    function automatic void chk(string nm, int act, int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    task automatic push_e(input int kind, input int slot, input int flag, input int c);
        exp_t e;
        e.kind = kind; e.slot = slot; e.flag = flag; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic go_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        clr_hash = 0; core_done = 0;
        s0_req = 0; s0_prm_vld = 0; s0_flg_384 = 0;
        s1_req = 0; s1_prm_vld = 0; s1_flg_384 = 0;
        rst_n = 0;
        #1;
        chk("reset_outputs",
            {s0_ack, s0_done, s0_err, s0_prm_clr, s1_ack, s1_done, s1_err, s1_prm_clr,
             core_start, core_slot, core_mode, busy}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    // Monitor: every launch/retire seen on the outputs consumes one expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            if (core_start) begin
                if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("start_kind", 0, e.kind);
                    chk("start_slot", core_slot, e.slot);
                    chk("start_mode", core_mode, e.flag);
                    chk("start_cycle", cyc, e.c);
                    chk("start_ack", {s1_ack, s0_ack}, (e.slot == 1) ? 2 : 1);
                end
            end else if (s0_ack || s1_ack) begin
                chk("ack_without_start", 1, 0);
            end
            if (s0_done || s1_done) begin
                chk("done_onehot", s0_done & s1_done, 0);
                if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("done_kind", 1, e.kind);
                    chk("done_slot", s1_done ? 1 : 0, e.slot);
                    chk("done_err", s1_done ? s1_err : s0_err, e.flag);
                    chk("done_prm_clr", {s1_prm_clr, s0_prm_clr}, {s1_done, s0_done});
                    chk("done_cycle", cyc, e.c);
                end
            end else if (s0_prm_clr || s1_prm_clr || s0_err || s1_err) begin
                chk("retire_side_pulse_alone", 1, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int t;
        @(negedge clk);
        do_reset();

        // 1: single slot-0 job in 384 mode, request at cycle 10
        s0_prm_vld = 1; s0_flg_384 = 1;
        go_to(10); s0_req = 1; push_e(0, 0, 1, 11);
        go_to(11); s0_req = 0; chk("t1_busy_start", busy, 1);
        go_to(14); core_done = 1; push_e(1, 0, 0, 15);
        go_to(15); core_done = 0; chk("t1_busy_done", busy, 1);
        go_to(16); chk("t1_busy_idle", busy, 0);

        // 2: simultaneous requests, round robin across two pairs
        do_reset();
        s0_prm_vld = 1; s0_flg_384 = 1; s1_prm_vld = 1; s1_flg_384 = 0;
        t = cyc + 2;
        go_to(t);      s0_req = 1; s1_req = 1; push_e(0, 0, 1, t + 1);
        go_to(t + 1);  s0_req = 0; s1_req = 0;
        go_to(t + 3);  core_done = 1; push_e(1, 0, 0, t + 4); push_e(0, 1, 0, t + 6);
        go_to(t + 4);  core_done = 0;
        go_to(t + 8);  core_done = 1; push_e(1, 1, 0, t + 9);
        go_to(t + 9);  core_done = 0;
        go_to(t + 12); s0_req = 1; s1_req = 1; push_e(0, 0, 1, t + 13);
        go_to(t + 13); s0_req = 0; s1_req = 0;
        go_to(t + 15); core_done = 1; push_e(1, 0, 0, t + 16); push_e(0, 1, 0, t + 18);
        go_to(t + 16); core_done = 0;
        go_to(t + 20); core_done = 1; push_e(1, 1, 0, t + 21);
        go_to(t + 21); core_done = 0;

        // 3: slot-1 watchdog expiry, then core_done on the final timer cycle
        do_reset();
        s1_prm_vld = 1; s1_flg_384 = 1;
        t = cyc + 2;
        go_to(t);      s1_req = 1; push_e(0, 1, 1, t + 1);
        go_to(t + 1);  s1_req = 0; push_e(1, 1, 1, t + 18);
        go_to(t + 17); chk("t3_busy_last_wait", busy, 1);
        go_to(t + 18); chk("t3_busy_done", busy, 1);
        go_to(t + 19); chk("t3_busy_idle", busy, 0);
        s0_prm_vld = 1; s0_flg_384 = 0;
        t = cyc + 1;
        go_to(t);      s0_req = 1; push_e(0, 0, 0, t + 1);
        go_to(t + 1);  s0_req = 0;
        go_to(t + 17); core_done = 1; push_e(1, 0, 0, t + 18);
        go_to(t + 18); core_done = 0;
        go_to(t + 19); chk("t3b_busy_idle", busy, 0);

        // 4: abort mid-WAIT drops pending slot 1 and keeps rr pointer
        do_reset();
        s0_prm_vld = 1; s0_flg_384 = 0; s1_prm_vld = 1; s1_flg_384 = 1;
        t = cyc + 2;
        go_to(t);      s0_req = 1; push_e(0, 0, 0, t + 1);
        go_to(t + 1);  s0_req = 0;
        go_to(t + 3);  s1_req = 1;
        go_to(t + 4);  s1_req = 0;
        go_to(t + 7);  clr_hash = 1;
        go_to(t + 8);  clr_hash = 0; chk("t4_busy_after_clr", busy, 0);
        go_to(t + 9);  core_done = 1;
        go_to(t + 10); core_done = 0; chk("t4_busy_late_done", busy, 0);
        go_to(t + 11); chk("t4_no_relaunch", {busy, core_start}, 0);
        go_to(t + 12); s0_req = 1; s1_req = 1; push_e(0, 0, 0, t + 13);
        go_to(t + 13); s0_req = 0; s1_req = 0;
        go_to(t + 14); core_done = 1; push_e(1, 0, 0, t + 15); push_e(0, 1, 1, t + 17);
        go_to(t + 15); core_done = 0;
        go_to(t + 18); core_done = 1; push_e(1, 1, 0, t + 19);
        go_to(t + 19); core_done = 0;

        // 5: request held pending until parameters become valid
        do_reset();
        s0_prm_vld = 0; s0_flg_384 = 1;
        t = cyc + 2;
        go_to(t);      s0_req = 1;
        go_to(t + 1);  s0_req = 0;
        go_to(t + 5);  chk("t5_idle_no_vld", busy, 0);
        s0_prm_vld = 1; push_e(0, 0, 1, t + 6);
        go_to(t + 8);  core_done = 1; push_e(1, 0, 0, t + 9);
        go_to(t + 9);  core_done = 0;

        // 6: re-request landing in the grant cycle launches slot 0 again
        do_reset();
        s0_prm_vld = 1; s0_flg_384 = 0; s1_prm_vld = 1; s1_flg_384 = 0;
        t = cyc + 2;
        go_to(t);      s1_req = 1; push_e(0, 1, 0, t + 1);
        go_to(t + 1);  s1_req = 0;
        go_to(t + 2);  s0_req = 1;
        go_to(t + 3);  s0_req = 0; core_done = 1; push_e(1, 1, 0, t + 4);
        go_to(t + 4);  core_done = 0;
        go_to(t + 5);  s0_req = 1; push_e(0, 0, 0, t + 6);
        go_to(t + 6);  s0_req = 0;
        go_to(t + 8);  core_done = 1; push_e(1, 0, 0, t + 9); push_e(0, 0, 0, t + 11);
        go_to(t + 9);  core_done = 0;
        go_to(t + 13); core_done = 1; push_e(1, 0, 0, t + 14);
        go_to(t + 14); core_done = 0;
        go_to(t + 16); chk("t6_busy_idle", busy, 0);

        go_to(cyc + 3);
        chk("expectations_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
